mem_mp0_rdcmd_arbiter: RTL
==========================

// Module: mem_mp0_rdcmd_arbiter
// PURPOSE
//  Shares the SHELL Mem Mp0 read data mover between two ROLE requesters (UDP and TCP apps).
//  - Arbitrates the 80-bit read-command streams onto the single Mp0 RdCmd channel.
//  - Stamps the requester ID into the command tag.
//  - Routes each returning 8-bit RdSts beat back to the requester that issued the command.
//  - Tracks outstanding commands per requester and throttles it at a limit.
//  Sits between the role apps and soMEM_Mp0_RdCmd / siMEM_Mp0_RdSts. The read data stream is not touched.
// PARAMETERS
//  OUTSTD_MAX  4   max in-flight commands per requester (1..7)
//  TAG_ID_BIT  64  cmd bit overwritten with requester ID (lsb of data mover tag [67:64])
// PORTS
//  piSHL_156_25Clk         in   1   clock
//  piSHL_156_25Rst         in   1   synchronous active-high reset
//  siReq0_RdCmd_tdata      in   80  requester 0 command
//  siReq0_RdCmd_tvalid     in   1   requester 0 command valid
//  siReq0_RdCmd_tready     out  1   requester 0 command accept
//  siReq1_RdCmd_tdata/tvalid/tready  in/in/out  80/1/1  requester 1 command
//  soMEM_Mp0_RdCmd_tdata   out  80  arbitrated command to data mover
//  soMEM_Mp0_RdCmd_tvalid  out  1   command valid
//  soMEM_Mp0_RdCmd_tready  in   1   data mover accept
//  siMEM_Mp0_RdSts_tdata   in   8   status; bit[0] = tag lsb = requester ID
//  siMEM_Mp0_RdSts_tvalid  in   1   status valid
//  siMEM_Mp0_RdSts_tready  out  1   status accept
//  soReq0_RdSts_tdata/tvalid/tready  out/out/in  8/1/1  status to requester 0
//  soReq1_RdSts_tdata/tvalid/tready  out/out/in  8/1/1  status to requester 1
//  poOutstd0, poOutstd1    out  3   current in-flight count per requester
//  poStsErr                out  1   sticky: status received for requester with zero in-flight
// BEHAVIOUR
//  Reset state: all tvalid/tready = 0, tdata = 0, counters = 0, poStsErr = 0, rr pointer = 1 (req0 wins first).
//  Reset mid-transfer aborts held beats; they are not replayed.
//  Command FSM states: C_IDLE, C_ISSUE.
//  - C_IDLE: eligible(i) = tvalid(i) && outstd(i) < OUTSTD_MAX.
//  - If both are eligible, grant the requester not granted last (round-robin). Otherwise grant the single eligible one.
//  - siReqX_RdCmd_tready = C_IDLE && grant(X) (combinational). Never asserted to both in one cycle.
//  - Accept at cycle N: register cmd with bit TAG_ID_BIT := X; outstd(X)++; go to C_ISSUE.
//  - soMEM tvalid = 1 from N+1. Command latency is 1 cycle.
//  - C_ISSUE: hold tdata/tvalid stable until soMEM tready. On the handshake, deassert tvalid and go to C_IDLE.
//  - Sustained throughput is at most 1 command per 2 cycles. Bandwidth is not critical.
//  Status FSM states: S_IDLE, S_ROUTE.
//  - S_IDLE: siMEM_Mp0_RdSts_tready = 1. On a handshake, latch the beat, dest = tdata[0], go to S_ROUTE.
//  - S_ROUTE: tready = 0. Drive soReq{dest}_RdSts tvalid with the latched data, from the cycle after acceptance.
//  - On requester tready: outstd(dest)--, back to S_IDLE.
//  Stray status (status arrives with outstd(dest) == 0):
//  - Set poStsErr (cleared only by reset).
//  - Drop the beat: no tvalid to the requester, return to S_IDLE next cycle, counter unchanged (no underflow).
//  Counter rules:
//  - Increment and decrement of the same counter in one cycle leaves it unchanged.
//  - A counter never exceeds OUTSTD_MAX, because eligibility blocks further grants.
//  - Width is 3 bits. No wrap-around is possible.
//  The command and status FSMs run independently. Simultaneous command accept and status delivery is legal.
// CONFIGURATION
//  ARB_STRICT_PRIO_EN
//  - Defined: requester 0 has fixed priority. Requester 1 is granted only when requester 0 is not eligible. The rr pointer is unused.
//  - Undefined (default): round-robin as above.
// TESTING
//  T1 reset: hold piSHL_156_25Rst 3 cycles with both tvalid=1 -> all tready/tvalid=0, poOutstd0/1=0, poStsErr=0.
//  T2 RR: both requesters continuously valid, Mp0 tready=1, 8 cmds -> grants alternate 0,1,0,1...
//     - First grant is req0.
//     - Tag bit64 matches the requester.
//     - Each cmd appears on soMEM exactly 1 cycle after acceptance.
//  T3 throttle: req0 issues 4 cmds, no status returned -> req0 tready stays 0, poOutstd0=4.
//     - Return sts 0x80 -> soReq0 gets 0x80, count goes to 3, a 5th cmd is accepted.
//  T4 routing/backpressure: sts 0x81 with soReq1 tready=0 for 5 cycles -> soReq1 tvalid held with stable data.
//     - siMEM RdSts tready=0 throughout.
//     - Delivered on the 6th cycle; poOutstd1 decrements by 1.
//  T5 stray: sts 0x81 with poOutstd1=0 -> poStsErr=1, no soReq1 tvalid, counters unchanged.
//  T6 simultaneous/strict: req0 cmd accept in the same cycle as req0 status delivery -> poOutstd0 unchanged.
//     - With ARB_STRICT_PRIO_EN defined and both valid: all grants go to req0 until its count reaches OUTSTD_MAX.

Source files
------------

// File: rtl/mem_mp0_rdcmd_arbiter.sv
// Two-requester arbiter for the SHELL Mem Mp0 read data mover: merges RdCmd streams, tags them, routes RdSts back.
// Build option: define ARB_STRICT_PRIO_EN for fixed requester-0 priority instead of round-robin.
module mem_mp0_rdcmd_arbiter #(
    parameter int OUTSTD_MAX = 4,
    parameter int TAG_ID_BIT = 64
) (
    input  logic        piSHL_156_25Clk,
    input  logic        piSHL_156_25Rst,
    input  logic [79:0] siReq0_RdCmd_tdata,
    input  logic        siReq0_RdCmd_tvalid,
    output logic        siReq0_RdCmd_tready,
    input  logic [79:0] siReq1_RdCmd_tdata,
    input  logic        siReq1_RdCmd_tvalid,
    output logic        siReq1_RdCmd_tready,
    output logic [79:0] soMEM_Mp0_RdCmd_tdata,
    output logic        soMEM_Mp0_RdCmd_tvalid,
    input  logic        soMEM_Mp0_RdCmd_tready,
    input  logic [7:0]  siMEM_Mp0_RdSts_tdata,
    input  logic        siMEM_Mp0_RdSts_tvalid,
    output logic        siMEM_Mp0_RdSts_tready,
    output logic [7:0]  soReq0_RdSts_tdata,
    output logic        soReq0_RdSts_tvalid,
    input  logic        soReq0_RdSts_tready,
    output logic [7:0]  soReq1_RdSts_tdata,
    output logic        soReq1_RdSts_tvalid,
    input  logic        soReq1_RdSts_tready,
    output logic [2:0]  poOutstd0,
    output logic [2:0]  poOutstd1,
    output logic        poStsErr
);

    localparam logic [2:0] LP_MAX = 3'(OUTSTD_MAX);

    typedef enum logic {C_IDLE, C_ISSUE} cstate_t;
    typedef enum logic {S_IDLE, S_ROUTE} sstate_t;

    cstate_t     r_cstate;
    cstate_t     w_cstate_nxt;
    sstate_t     r_sstate;
    sstate_t     w_sstate_nxt;

    logic [2:0]  r_outstd0;
    logic [2:0]  r_outstd1;
    logic        w_elig0;
    logic        w_elig1;
    logic        w_cmd_idle;
    logic        w_grant0;
    logic        w_grant1;
    logic [79:0] w_cmd_tagged;
    logic [79:0] r_cmd_data;
    logic        r_cmd_vld;

    logic        w_sts_idle;
    logic        w_sts_acc;
    logic        w_sts_stray;
    logic        w_sts_vld;
    logic        w_dlv0;
    logic        w_dlv1;
    logic [7:0]  r_sts_data;
    logic        r_sts_dest;
    logic        r_sts_drop;
    logic        r_sts_err;

    // Saturation is impossible by construction; a same-cycle inc+dec cancels.
    function automatic logic [2:0] f_cnt_next(input logic [2:0] cur,
                                              input logic inc,
                                              input logic dec);
        logic [2:0] v;
        v = cur;
        if (inc && !dec) begin
            v = cur + 3'd1;
        end else if (dec && !inc) begin
            v = cur - 3'd1;
        end
        return v;
    endfunction

    assign w_elig0    = siReq0_RdCmd_tvalid && (r_outstd0 < LP_MAX);
    assign w_elig1    = siReq1_RdCmd_tvalid && (r_outstd1 < LP_MAX);
    assign w_cmd_idle = (r_cstate == C_IDLE) && !piSHL_156_25Rst;

`ifdef ARB_STRICT_PRIO_EN
    assign w_grant0 = w_cmd_idle && w_elig0;
    assign w_grant1 = w_cmd_idle && w_elig1 && !w_elig0;
`else
    // r_rr_last: 1 when requester 1 held the last grant, so requester 0 wins next tie.
    logic r_rr_last;

    assign w_grant0 = w_cmd_idle && w_elig0 && (!w_elig1 || r_rr_last);
    assign w_grant1 = w_cmd_idle && w_elig1 && (!w_elig0 || !r_rr_last);

    always_ff @(posedge piSHL_156_25Clk) begin
        if (piSHL_156_25Rst) begin
            r_rr_last <= 1'b1;
        end else if (w_grant0) begin
            r_rr_last <= 1'b0;
        end else if (w_grant1) begin
            r_rr_last <= 1'b1;
        end
    end
`endif

    assign siReq0_RdCmd_tready = w_grant0;
    assign siReq1_RdCmd_tready = w_grant1;

    always_comb begin
        w_cmd_tagged             = w_grant1 ? siReq1_RdCmd_tdata : siReq0_RdCmd_tdata;
        w_cmd_tagged[TAG_ID_BIT] = w_grant1;
    end

    always_ff @(posedge piSHL_156_25Clk) begin
        if (piSHL_156_25Rst) begin
            r_cstate <= C_IDLE;
        end else begin
            r_cstate <= w_cstate_nxt;
        end
    end

    always_comb begin
        w_cstate_nxt = r_cstate;
        if (r_cstate == C_IDLE) begin
            if (w_grant0 || w_grant1) begin
                w_cstate_nxt = C_ISSUE;
            end
        end else begin
            if (soMEM_Mp0_RdCmd_tready) begin
                w_cstate_nxt = C_IDLE;
            end
        end
    end

    // Command register: captured on grant, held until the data mover accepts.
    always_ff @(posedge piSHL_156_25Clk) begin
        if (piSHL_156_25Rst) begin
            r_cmd_data <= '0;
            r_cmd_vld  <= 1'b0;
        end else if (w_grant0 || w_grant1) begin
            r_cmd_data <= w_cmd_tagged;
            r_cmd_vld  <= 1'b1;
        end else if (r_cmd_vld && soMEM_Mp0_RdCmd_tready) begin
            r_cmd_vld  <= 1'b0;
        end
    end

    assign soMEM_Mp0_RdCmd_tdata  = r_cmd_data;
    assign soMEM_Mp0_RdCmd_tvalid = r_cmd_vld;

    assign w_sts_idle             = (r_sstate == S_IDLE) && !piSHL_156_25Rst;
    assign siMEM_Mp0_RdSts_tready = w_sts_idle;
    assign w_sts_acc              = w_sts_idle && siMEM_Mp0_RdSts_tvalid;
    assign w_sts_stray            = w_sts_acc &&
                                    (siMEM_Mp0_RdSts_tdata[0] ? (r_outstd1 == 3'd0)
                                                              : (r_outstd0 == 3'd0));

    always_ff @(posedge piSHL_156_25Clk) begin
        if (piSHL_156_25Rst) begin
            r_sstate <= S_IDLE;
        end else begin
            r_sstate <= w_sstate_nxt;
        end
    end

    always_comb begin
        w_sstate_nxt = r_sstate;
        if (r_sstate == S_IDLE) begin
            if (w_sts_acc) begin
                w_sstate_nxt = S_ROUTE;
            end
        end else begin
            if (r_sts_drop || w_dlv0 || w_dlv1) begin
                w_sstate_nxt = S_IDLE;
            end
        end
    end

    // Status beat register; a stray beat is latched with r_sts_drop so it is discarded.
    always_ff @(posedge piSHL_156_25Clk) begin
        if (piSHL_156_25Rst) begin
            r_sts_data <= '0;
            r_sts_dest <= 1'b0;
            r_sts_drop <= 1'b0;
            r_sts_err  <= 1'b0;
        end else begin
            if (w_sts_acc) begin
                r_sts_data <= siMEM_Mp0_RdSts_tdata;
                r_sts_dest <= siMEM_Mp0_RdSts_tdata[0];
                r_sts_drop <= w_sts_stray;
            end
            if (w_sts_stray) begin
                r_sts_err <= 1'b1;
            end
        end
    end

    assign w_sts_vld           = (r_sstate == S_ROUTE) && !r_sts_drop;
    assign soReq0_RdSts_tvalid = w_sts_vld && !r_sts_dest;
    assign soReq1_RdSts_tvalid = w_sts_vld && r_sts_dest;
    assign soReq0_RdSts_tdata  = r_sts_data;
    assign soReq1_RdSts_tdata  = r_sts_data;
    assign w_dlv0              = soReq0_RdSts_tvalid && soReq0_RdSts_tready;
    assign w_dlv1              = soReq1_RdSts_tvalid && soReq1_RdSts_tready;

    always_ff @(posedge piSHL_156_25Clk) begin
        if (piSHL_156_25Rst) begin
            r_outstd0 <= 3'd0;
            r_outstd1 <= 3'd0;
        end else begin
            r_outstd0 <= f_cnt_next(r_outstd0, w_grant0, w_dlv0);
            r_outstd1 <= f_cnt_next(r_outstd1, w_grant1, w_dlv1);
        end
    end

    assign poOutstd0 = r_outstd0;
    assign poOutstd1 = r_outstd1;
    assign poStsErr  = r_sts_err;

    a_one_grant: assert property (@(posedge piSHL_156_25Clk)
        !(siReq0_RdCmd_tready && siReq1_RdCmd_tready));
    a_cnt_bound: assert property (@(posedge piSHL_156_25Clk)
        (r_outstd0 <= LP_MAX) && (r_outstd1 <= LP_MAX));

endmodule
